multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
- Multi-cycle FSM that sequences the core datapath: instruction fetch over a valid/ready memory port, IR latch, decode, execute, optional data-memory access, and writeback/PC update.
- Gates the combinational decoder's register-write and PC controls so that each fires exactly once per instruction.
- Sits between the instruction/data memory ports, the IR, the decoder, the register file and the PC.

Parameters:
- TIMEOUT_WIDTH, 8: width of the memory-wait watchdog counter. Fault when the counter reaches 2^TIMEOUT_WIDTH-1.
- RETIRE_WIDTH, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- imem_req_valid  out  1  fetch request at address = current PC (PC is held outside this block).
- imem_req_ready  in  1  fetch request accepted.
- imem_resp_valid  in  1  fetch data valid.
- imem_resp_data  in  32  fetched instruction.
- instruction  out  32  latched IR, drives the decoder.
- dmem_req_valid  out  1  load/store request.
- dmem_req_write  out  1  1 = store; valid only while dmem_req_valid.
- dmem_req_ready  in  1  data request accepted.
- dmem_resp_valid  in  1  load data valid, or store complete.
- decode_register_write_enable  in  1  decoder's raw register write enable.
- register_write_enable  out  1  gated register file write strobe.
- pc_write_enable  out  1  PC update strobe.
- fault  out  1  sticky trap indication.
- fault_code  out  2  0 none, 1 illegal opcode, 2 fetch timeout, 3 data timeout.
- retired_count  out  RETIRE_WIDTH  instructions completed.

Behaviour:
- Reset (rst_n=0 sampled at a clock edge) forces the following, regardless of current state:
  - state=FETCH_REQ, instruction=32'h00000013 (nop);
  - all strobes 0, fault=0, fault_code=0, retired_count=0, watchdog=0.
- States: FETCH_REQ, FETCH_WAIT, DECODE, EXECUTE, MEM_REQ, MEM_WAIT, WRITEBACK, TRAP.
- FETCH_REQ:
  - imem_req_valid=1.
  - On imem_req_ready -> FETCH_WAIT. valid stays high until accepted; no retraction.
- FETCH_WAIT:
  - On imem_resp_valid: IR <= imem_resp_data, go to DECODE.
  - A response in the same cycle as acceptance is ignored; responses are sampled from FETCH_WAIT only.
- DECODE (one cycle): check opcode = instruction[6:0].
  - Legal: 0110011, 0010011, 1100111, 0110111, 0010111, 1101111, 0000011, 0100011 -> EXECUTE.
  - Anything else -> TRAP with code 1.
- EXECUTE (one cycle, ALU settles):
  - Load (0000011) or store (0100011) -> MEM_REQ.
  - Otherwise -> WRITEBACK.
- MEM_REQ:
  - dmem_req_valid=1; dmem_req_write=1 for store opcode.
  - On dmem_req_ready -> MEM_WAIT.
- MEM_WAIT: on dmem_resp_valid -> WRITEBACK.
- WRITEBACK (exactly one cycle):
  - pc_write_enable=1.
  - register_write_enable = decode_register_write_enable, OR 1 for a load; 0 for a store.
  - retired_count += 1, wrapping modulo 2^RETIRE_WIDTH.
  - Next state FETCH_REQ.
- Strobes: register_write_enable and pc_write_enable are never high outside WRITEBACK.
- Latency: a non-memory instruction takes 5 cycles when memory responds with zero wait (FETCH_REQ, FETCH_WAIT, DECODE, EXECUTE, WRITEBACK). Loads and stores take 7.
- Watchdog:
  - Counts every cycle spent in FETCH_REQ, FETCH_WAIT, MEM_REQ or MEM_WAIT.
  - Clears on every state transition.
  - At terminal count -> TRAP with code 2 (fetch states) or 3 (memory states).
  - A handshake completing in the terminal-count cycle wins; no fault is raised.
- TRAP:
  - All request and strobe outputs 0; fault=1; fault_code held.
  - Exit only by reset. IR and retired_count frozen.
- Combinational paths: requests are Moore outputs of the state only. No combinational path from ready/valid inputs to request outputs.

Decomposition:
- Shared package (core_pkg) holds:
  - opcode constants: OP_R, OP_I, OP_JALR, OP_LUI, OP_AUIPC, OP_JAL, OP_LOAD, OP_STORE;
  - the state enum;
  - fault_code constants;
  - the NOP encoding.
- One sub-module, sequencer_watchdog: the counter with clear/enable inputs and a terminal-count flag.

Test Plan:
- Zero-wait memory, IR=0x00500093 (addi x1,x0,5) -> register_write_enable and pc_write_enable high together for exactly one cycle, 4 cycles after fetch acceptance; retired_count=1.
- Load 0x00002183 (lw x3,0(x0)) with dmem_req_ready delayed 3 cycles -> dmem_req_valid held 4 cycles, dmem_req_write=0, register_write_enable=1 in WRITEBACK.
- Store 0x00302023 with decode_register_write_enable forced 1 -> dmem_req_write=1, register_write_enable=0 throughout, retired_count increments.
- IR=0xFFFFFFFF -> TRAP after DECODE, fault=1, fault_code=1, no strobes, imem_req_valid stays 0 until rst_n=0 for one cycle, then FETCH_REQ with retired_count=0.
- TIMEOUT_WIDTH=4, imem_req_ready held 0 -> fault_code=2 after 15 cycles in FETCH_REQ. Repeat with ready asserted on cycle 15 -> no fault.
- rst_n=0 asserted in MEM_WAIT with dmem_resp_valid=1 in the same cycle -> next state FETCH_REQ, no register_write_enable pulse, retired_count=0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, sequencer states, fault codes.
// Latency: none (constants, types and one pure function).
// Backpressure: not applicable.
package core_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  localparam logic [1:0] FAULT_NONE          = 2'd0;
  localparam logic [1:0] FAULT_ILLEGAL       = 2'd1;
  localparam logic [1:0] FAULT_FETCH_TIMEOUT = 2'd2;
  localparam logic [1:0] FAULT_DATA_TIMEOUT  = 2'd3;

  typedef enum logic [2:0] {
    FETCH_REQ,
    FETCH_WAIT,
    DECODE,
    EXECUTE,
    MEM_REQ,
    MEM_WAIT,
    WRITEBACK,
    TRAP
  } state_t;

  function automatic logic opcode_legal(input logic [6:0] op);
    return (op == OP_R)   || (op == OP_I)     || (op == OP_JALR) || (op == OP_LUI) ||
           (op == OP_AUIPC) || (op == OP_JAL) || (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Instruction and data memory handshake bundle between the sequencer and the memories.
// Latency: none (wires only).
// Backpressure: valid/ready on requests, responses are valid-only.
interface multicycle_sequencer_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        dmem_req_valid;
  logic        dmem_req_write;
  logic        dmem_req_ready;
  logic        dmem_resp_valid;

  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data,
    output dmem_req_valid,
    output dmem_req_write,
    input  dmem_req_ready,
    input  dmem_resp_valid
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data,
    input  dmem_req_valid,
    input  dmem_req_write,
    output dmem_req_ready,
    output dmem_resp_valid
  );
endinterface

// File: rtl/sequencer_watchdog.sv
// Counts stalled cycles; flags the cycle in which the count would reach all-ones.
// Latency: terminal is combinational from the registered count and enable.
// Backpressure: none; clear has priority over enable.
module sequencer_watchdog #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);
  // The last count before all-ones: the transition out of this cycle is the timeout.
  localparam logic [WIDTH-1:0] LAST = {{(WIDTH-1){1'b1}}, 1'b0};

  logic [WIDTH-1:0] count;

  // Stall counter: restarts on every state change, advances while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = enable && (count == LAST);
endmodule

// File: rtl/multicycle_sequencer.sv
// Sequences fetch, decode, execute, optional data access and writeback for the core.
// Latency: 5 cycles per non-memory instruction, 7 per load/store with zero-wait memory.
// Backpressure: requests hold valid until ready; a watchdog traps a stalled memory.
module multicycle_sequencer
  import core_pkg::*;
#(
  parameter int TIMEOUT_WIDTH = 8,
  parameter int RETIRE_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_sequencer_if.master  mem,
  output logic [31:0]             instruction,
  input  logic                    decode_register_write_enable,
  output logic                    register_write_enable,
  output logic                    pc_write_enable,
  output logic                    fault,
  output logic [1:0]              fault_code,
  output logic [RETIRE_WIDTH-1:0] retired_count
);
  state_t     state;
  state_t     state_next;
  logic [1:0] trap_code;
  logic [6:0] opcode;
  logic       is_load;
  logic       is_store;
  logic       wd_clear;
  logic       wd_enable;
  logic       wd_terminal;

  assign opcode    = instruction[6:0];
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign wd_enable = (state == FETCH_REQ) || (state == FETCH_WAIT) ||
                     (state == MEM_REQ)   || (state == MEM_WAIT);
  assign wd_clear  = (state_next != state);

  sequencer_watchdog #(.WIDTH(TIMEOUT_WIDTH)) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (wd_clear),
    .enable   (wd_enable),
    .terminal (wd_terminal)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH_REQ;
    end else begin
      state <= state_next;
    end
  end

  // Next state; a handshake in the terminal-count cycle is checked first so it wins.
  always_comb begin
    state_next = state;
    trap_code  = FAULT_NONE;
    case (state)
      FETCH_REQ: begin
        if (mem.imem_req_ready) begin
          state_next = FETCH_WAIT;
        end else if (wd_terminal) begin
          state_next = TRAP;
          trap_code  = FAULT_FETCH_TIMEOUT;
        end
      end
      FETCH_WAIT: begin
        if (mem.imem_resp_valid) begin
          state_next = DECODE;
        end else if (wd_terminal) begin
          state_next = TRAP;
          trap_code  = FAULT_FETCH_TIMEOUT;
        end
      end
      DECODE: begin
        if (opcode_legal(opcode)) begin
          state_next = EXECUTE;
        end else begin
          state_next = TRAP;
          trap_code  = FAULT_ILLEGAL;
        end
      end
      EXECUTE:   state_next = (is_load || is_store) ? MEM_REQ : WRITEBACK;
      MEM_REQ: begin
        if (mem.dmem_req_ready) begin
          state_next = MEM_WAIT;
        end else if (wd_terminal) begin
          state_next = TRAP;
          trap_code  = FAULT_DATA_TIMEOUT;
        end
      end
      MEM_WAIT: begin
        if (mem.dmem_resp_valid) begin
          state_next = WRITEBACK;
        end else if (wd_terminal) begin
          state_next = TRAP;
          trap_code  = FAULT_DATA_TIMEOUT;
        end
      end
      WRITEBACK: state_next = FETCH_REQ;
      TRAP:      state_next = TRAP;
      default:   state_next = FETCH_REQ;
    endcase
  end

  // Outputs decoded from state only, except the write strobe which passes the decoder's enable.
  always_comb begin
    mem.imem_req_valid    = 1'b0;
    mem.dmem_req_valid    = 1'b0;
    mem.dmem_req_write    = 1'b0;
    pc_write_enable       = 1'b0;
    register_write_enable = 1'b0;
    fault                 = 1'b0;
    case (state)
      FETCH_REQ: mem.imem_req_valid = 1'b1;
      MEM_REQ: begin
        mem.dmem_req_valid = 1'b1;
        mem.dmem_req_write = is_store;
      end
      WRITEBACK: begin
        pc_write_enable       = 1'b1;
        register_write_enable = is_load || (decode_register_write_enable && !is_store);
      end
      TRAP:      fault = 1'b1;
      default: ;
    endcase
  end

  // IR, retire counter and fault code; all frozen once trapped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instruction   <= NOP_INSN;
      retired_count <= '0;
      fault_code    <= FAULT_NONE;
    end else begin
      if (state == FETCH_WAIT && mem.imem_resp_valid) begin
        instruction <= mem.imem_resp_data;
      end
      if (state == WRITEBACK) begin
        retired_count <= retired_count + 1'b1;
      end
      if (state != TRAP && state_next == TRAP) begin
        fault_code <= trap_code;
      end
    end
  end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench: directed and randomized instructions against a cycle-budget model.
// Latency: expected timing derived from per-phase wait counts.
// Backpressure: memory ready/valid delays are randomized, with noise where inputs are ignored.
module tb_multicycle_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instruction;
  logic        decode_register_write_enable = 1'b0;
  logic        register_write_enable;
  logic        pc_write_enable;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] retired_count;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] exp_retired = '0;

  logic [6:0] legal_ops [8] = '{7'b0110011, 7'b0010011, 7'b1100111, 7'b0110111,
                                7'b0010111, 7'b1101111, 7'b0000011, 7'b0100011};

  multicycle_sequencer_if bus();

  multicycle_sequencer #(.TIMEOUT_WIDTH(4), .RETIRE_WIDTH(32)) dut (
    .clk                          (clk),
    .rst_n                        (rst_n),
    .mem                          (bus),
    .instruction                  (instruction),
    .decode_register_write_enable (decode_register_write_enable),
    .register_write_enable        (register_write_enable),
    .pc_write_enable              (pc_write_enable),
    .fault                        (fault),
    .fault_code                   (fault_code),
    .retired_count                (retired_count)
  );

  always #5 clk = ~clk;

  function automatic bit coin();
    return $urandom_range(0, 1) == 1;
  endfunction

  function automatic bit legal(input logic [6:0] op);
    for (int i = 0; i < 8; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_inputs();
    bus.imem_req_ready = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data = '0;
    bus.dmem_req_ready = 1'b0;
    bus.dmem_resp_valid = 1'b0;
    decode_register_write_enable = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(posedge clk);
    #1;
    exp_retired = '0;
    tests_run += 6;
    if (bus.imem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL reset_ireq got %b want 1", bus.imem_req_valid); end
    if ({bus.dmem_req_valid, pc_write_enable, register_write_enable} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_strobes got %b want 000", {bus.dmem_req_valid, pc_write_enable, register_write_enable}); end
    if (fault !== 1'b0) begin tests_failed++; $display("FAIL reset_fault got %b want 0", fault); end
    if (fault_code !== 2'd0) begin tests_failed++; $display("FAIL reset_code got %0d want 0", fault_code); end
    if (retired_count !== 32'd0) begin tests_failed++; $display("FAIL reset_retired got %0d want 0", retired_count); end
    if (instruction !== 32'h0000_0013) begin tests_failed++; $display("FAIL reset_ir got %h want 00000013", instruction); end
    rst_n = 1'b1;
  endtask

  // One instruction from FETCH_REQ with given waits (cycles before each ready/valid arrives).
  task automatic run_insn(input string name, input logic [31:0] insn, input logic dwe,
                          input int di_rdy, input int di_resp, input int dd_rdy, input int dd_resp);
    bit is_load, is_store, is_mem, exp_we;
    int a, r, m, q, wb;
    int n_ireq, n_dreq, n_dwr, n_pc, n_we, pc_at, we_at, n_fault;
    is_load = (insn[6:0] == 7'b0000011);
    is_store = (insn[6:0] == 7'b0100011);
    is_mem = is_load || is_store;
    exp_we = is_load || (dwe && !is_store);
    a = di_rdy;
    r = a + 1 + di_resp;
    m = is_mem ? r + 3 + dd_rdy : -100;
    q = is_mem ? m + 1 + dd_resp : -100;
    wb = is_mem ? q + 1 : r + 3;
    n_ireq = 0; n_dreq = 0; n_dwr = 0; n_pc = 0; n_we = 0; pc_at = -1; we_at = -1; n_fault = 0;
    for (int t = 0; t <= wb; t++) begin
      @(negedge clk);
      decode_register_write_enable = dwe;
      bus.imem_req_ready = (t == a) || (t > a && coin());
      bus.imem_resp_valid = (t == r) || ((t <= a || t > r) && coin());
      bus.imem_resp_data = (t == r) ? insn : $urandom;
      if (is_mem) begin
        bus.dmem_req_ready = (t == m) || ((t < r + 3 || t > m) && coin());
        bus.dmem_resp_valid = (t == q) || ((t <= m || t > q) && coin());
      end else begin
        bus.dmem_req_ready = coin();
        bus.dmem_resp_valid = coin();
      end
      #1;
      if (bus.imem_req_valid) n_ireq++;
      if (bus.dmem_req_valid) n_dreq++;
      if (bus.dmem_req_valid && bus.dmem_req_write) n_dwr++;
      if (pc_write_enable) begin n_pc++; if (pc_at < 0) pc_at = t; end
      if (register_write_enable) begin n_we++; if (we_at < 0) we_at = t; end
      if (fault) n_fault++;
    end
    @(posedge clk);
    #1;
    exp_retired = exp_retired + 1;
    tests_run += 9;
    if (n_ireq != a + 1) begin tests_failed++; $display("FAIL %s ireq_cycles got %0d want %0d", name, n_ireq, a + 1); end
    if (n_dreq != (is_mem ? dd_rdy + 1 : 0)) begin tests_failed++; $display("FAIL %s dreq_cycles got %0d want %0d", name, n_dreq, is_mem ? dd_rdy + 1 : 0); end
    if (n_dwr != (is_store ? dd_rdy + 1 : 0)) begin tests_failed++; $display("FAIL %s dwrite_cycles got %0d want %0d", name, n_dwr, is_store ? dd_rdy + 1 : 0); end
    if (n_pc != 1 || pc_at != wb) begin tests_failed++; $display("FAIL %s pc_strobe got %0d@%0d want 1@%0d", name, n_pc, pc_at, wb); end
    if (n_we != (exp_we ? 1 : 0)) begin tests_failed++; $display("FAIL %s we_count got %0d want %0d", name, n_we, exp_we ? 1 : 0); end
    if (exp_we && we_at != wb) begin tests_failed++; $display("FAIL %s we_cycle got %0d want %0d", name, we_at, wb); end
    if (n_fault != 0) begin tests_failed++; $display("FAIL %s fault_cycles got %0d want 0", name, n_fault); end
    if (retired_count !== exp_retired) begin tests_failed++; $display("FAIL %s retired got %0d want %0d", name, retired_count, exp_retired); end
    if (instruction !== insn) begin tests_failed++; $display("FAIL %s ir got %h want %h", name, instruction, insn); end
  endtask

  task automatic test_back_to_back(input int count);
    logic [31:0] insn;
    for (int i = 0; i < count; i++) begin
      insn = $urandom;
      insn[6:0] = legal_ops[$urandom_range(0, 7)];
      run_insn("random", insn, coin(), $urandom_range(0, 6), $urandom_range(0, 6),
               $urandom_range(0, 6), $urandom_range(0, 6));
    end
  endtask

  task automatic test_illegal(input logic [31:0] insn);
    int n_fault, n_code, n_strobe, n_ir, n_ret;
    n_fault = 0; n_code = 0; n_strobe = 0; n_ir = 0; n_ret = 0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      clear_inputs();
      bus.imem_req_ready = (t == 0);
      bus.imem_resp_valid = (t == 1);
      bus.imem_resp_data = insn;
    end
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      bus.imem_req_ready = coin();
      bus.imem_resp_valid = coin();
      bus.imem_resp_data = $urandom;
      bus.dmem_req_ready = coin();
      bus.dmem_resp_valid = coin();
      decode_register_write_enable = coin();
      #1;
      if (fault === 1'b1) n_fault++;
      if (fault_code === 2'd1) n_code++;
      if (bus.imem_req_valid || bus.dmem_req_valid || pc_write_enable || register_write_enable) n_strobe++;
      if (instruction === insn) n_ir++;
      if (retired_count === exp_retired) n_ret++;
    end
    tests_run += 5;
    if (n_fault != 10) begin tests_failed++; $display("FAIL illegal_fault got %0d want 10 cycles", n_fault); end
    if (n_code != 10) begin tests_failed++; $display("FAIL illegal_code got %0d want 10 cycles of code 1", n_code); end
    if (n_strobe != 0) begin tests_failed++; $display("FAIL illegal_strobes got %0d want 0", n_strobe); end
    if (n_ir != 10) begin tests_failed++; $display("FAIL illegal_ir_frozen got %0d want 10", n_ir); end
    if (n_ret != 10) begin tests_failed++; $display("FAIL illegal_retired_frozen got %0d want 10", n_ret); end
    test_reset();
  endtask

  // Stall in one waiting phase (0 fetch req, 1 fetch wait, 2 mem req, 3 mem wait) until trap.
  task automatic test_timeout(input int phase);
    logic [31:0] insn;
    int s, n_ireq, n_dreq;
    logic [1:0] want;
    insn = (phase >= 2) ? 32'h0000_2183 : 32'h0050_0093;
    s = (phase == 0) ? 0 : (phase == 1) ? 1 : (phase == 2) ? 4 : 5;
    want = (phase < 2) ? 2'd2 : 2'd3;
    n_ireq = 0; n_dreq = 0;
    for (int t = 0; t <= s + 15; t++) begin
      @(negedge clk);
      clear_inputs();
      bus.imem_req_ready = (phase != 0 && t == 0);
      bus.imem_resp_valid = (phase > 1 && t == 1);
      bus.imem_resp_data = insn;
      bus.dmem_req_ready = (phase == 3 && t == 4);
      #1;
      if (bus.imem_req_valid) n_ireq++;
      if (bus.dmem_req_valid) n_dreq++;
      if (t == s + 14) begin
        tests_run++;
        if (fault !== 1'b0) begin tests_failed++; $display("FAIL timeout%0d_early got fault %b want 0", phase, fault); end
      end
      if (t == s + 15) begin
        tests_run += 2;
        if (fault !== 1'b1 || fault_code !== want) begin
          tests_failed++; $display("FAIL timeout%0d_trap got %b/%0d want 1/%0d", phase, fault, fault_code, want); end
        if (bus.imem_req_valid || bus.dmem_req_valid) begin
          tests_failed++; $display("FAIL timeout%0d_req got %b%b want 00", phase, bus.imem_req_valid, bus.dmem_req_valid); end
      end
    end
    tests_run += 2;
    if (n_ireq != ((phase == 0) ? 15 : 1)) begin tests_failed++; $display("FAIL timeout%0d_ireq got %0d want %0d", phase, n_ireq, (phase == 0) ? 15 : 1); end
    if (n_dreq != ((phase == 2) ? 15 : (phase == 3) ? 1 : 0)) begin
      tests_failed++; $display("FAIL timeout%0d_dreq got %0d want %0d", phase, n_dreq, (phase == 2) ? 15 : (phase == 3) ? 1 : 0); end
    test_reset();
  endtask

  task automatic test_reset_in_mem_wait();
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      clear_inputs();
      bus.imem_req_ready = (t == 0);
      bus.imem_resp_valid = (t == 1);
      bus.imem_resp_data = 32'h0000_2183;
      bus.dmem_req_ready = (t == 4);
      if (t == 5) begin
        rst_n = 1'b0;
        bus.dmem_resp_valid = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_inputs();
    tests_run += 4;
    if (bus.imem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL rst_memwait_ireq got %b want 1", bus.imem_req_valid); end
    if (register_write_enable !== 1'b0 || pc_write_enable !== 1'b0) begin
      tests_failed++; $display("FAIL rst_memwait_strobes got %b%b want 00", register_write_enable, pc_write_enable); end
    if (retired_count !== 32'd0) begin tests_failed++; $display("FAIL rst_memwait_retired got %0d want 0", retired_count); end
    if (instruction !== 32'h0000_0013) begin tests_failed++; $display("FAIL rst_memwait_ir got %h want 00000013", instruction); end
    exp_retired = '0;
    run_insn("after_reset", 32'h0050_0093, 1'b1, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] bad;
    clear_inputs();
    test_reset();
    run_insn("addi_zero_wait", 32'h0050_0093, 1'b1, 0, 0, 0, 0);
    run_insn("lw_ready_delay3", 32'h0000_2183, 1'b0, 0, 0, 3, 0);
    run_insn("sw_dec_we", 32'h0030_2023, 1'b1, 0, 0, 0, 0);
    test_back_to_back(40);
    run_insn("tc_edge_load", 32'h0000_2183, 1'b0, 14, 14, 14, 14);
    run_insn("tc_edge_store", 32'h0030_2023, 1'b1, 14, 14, 14, 14);
    for (int p = 0; p < 4; p++) test_timeout(p);
    test_illegal(32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      bad = $urandom;
      while (legal(bad[6:0])) bad[6:0] = 7'($urandom_range(0, 127));
      test_illegal(bad);
    end
    test_reset_in_mem_wait();
    test_back_to_back(10);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
